// File: rtl/apb_slave_bridge_if.sv
// APB bus bundle between a requester (master modport) and apb_slave_bridge (slave modport).
interface apb_slave_bridge_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_bridge.sv
// APB completer bridging single accesses to a simple backend request/ack port.
// Define APB_SLAVE_BRIDGE_TIMEOUT_EN to fail backend waits after TIMEOUT cycles without ack.
module apb_slave_bridge #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                prst_n,
  apb_slave_bridge_if.slave   apb,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   waddr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                wack,
  input  logic                waddrerr,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   raddr,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rack,
  input  logic                raddrerr
);

  localparam int unsigned StrbW = DATA_W / 8;

  if ((DATA_W != 8) && (DATA_W != 16) && (DATA_W != 32)) begin : g_bad_data_w
    $error("apb_slave_bridge: DATA_W must be 8, 16 or 32");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("apb_slave_bridge: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StWWait, StRWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    strb_q, strb_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic accept;
  logic w_done;
  logic r_done;
  logic to_hit;

  assign accept = (state_q == StIdle) && apb.psel && apb.penable;
  // Only the ack/error type matching the pending access can complete it.
  assign w_done = (state_q == StWWait) && (wack || waddrerr);
  assign r_done = (state_q == StRWait) && (rack || raddrerr);

`ifdef APB_SLAVE_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_wait;

  assign in_wait = (state_q == StWWait) || (state_q == StRWait);
  // Counter reads 0 in the first wait cycle because it is held clear outside WAIT.
  assign cnt_d   = in_wait ? cnt_q + 1'b1 : '0;
  assign to_hit  = in_wait && !(w_done || r_done) && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = apb.pwrite ? StWWait : StRWait;
      StWWait: if (w_done || to_hit) state_d = StResp;
      StRWait: if (r_done || to_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Backend request is decoded from state; APB response is staged one cycle ahead so it
  // appears registered exactly in the RESP cycle.
  always_comb begin
    wr_en     = 1'b0;
    waddr     = '0;
    wdata     = '0;
    wstrb     = '0;
    rd_en     = 1'b0;
    raddr     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = apb.paddr;
          wdata_d = apb.pwdata;
          strb_d  = apb.pstrb;
        end
      end
      StWWait: begin
        wr_en = 1'b1;
        waddr = addr_q;
        wdata = wdata_q;
        wstrb = strb_q;
        if (w_done || to_hit) begin
          pready_d  = 1'b1;
          pslverr_d = w_done ? waddrerr : 1'b1;
        end
      end
      StRWait: begin
        rd_en = 1'b1;
        raddr = addr_q;
        if (r_done || to_hit) begin
          pready_d  = 1'b1;
          pslverr_d = r_done ? raddrerr : 1'b1;
          if (r_done && !raddrerr) prdata_d = rdata;
        end
      end
      default: ;
    endcase
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule
